// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM sequencing one MIPS instruction over 3-5 clocks
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       instr_done,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
   } state_t;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
   logic [3:0] st;
   logic mw, rw, iw, pw, br, dn, known;
   assign known = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
   assign state = st;
   always_ff @(posedge clk)
      if (reset) st <= FETCH;
      else
         case (st)
            FETCH:   st <= DECODE;
            DECODE:  st <= (op == OP_LW || op == OP_SW) ? MEMADR :
                           op == OP_R    ? RTYPEEX :
                           op == OP_BEQ  ? BEQEX :
                           op == OP_ADDI ? ADDIEX :
                           op == OP_J    ? JEX : FETCH;
            MEMADR:  st <= op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   st <= MEMWB;
            RTYPEEX: st <= RTYPEWB;
            ADDIEX:  st <= ADDIWB;
            default: st <= FETCH;
         endcase
   // raw strobes are gated by reset so an aborted instruction never writes
   always_comb begin
      {iord, regdst, memtoreg, alusrca, alusrcb, aluop, pcsrc, mw, rw, iw, pw, br, dn} = '0;
      case (st)
         FETCH:   begin iw = 1'b1; pw = 1'b1; alusrcb = 2'b01; end
         DECODE:  begin alusrcb = 2'b11; dn = ~known; end
         MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         MEMRD:   iord = 1'b1;
         MEMWB:   begin rw = 1'b1; memtoreg = 1'b1; dn = 1'b1; end
         MEMWR:   begin iord = 1'b1; mw = 1'b1; dn = 1'b1; end
         RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
         RTYPEWB: begin rw = 1'b1; regdst = 1'b1; dn = 1'b1; end
         BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; br = 1'b1; dn = 1'b1; end
         ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         ADDIWB:  begin rw = 1'b1; dn = 1'b1; end
         JEX:     begin pcsrc = 2'b10; pw = 1'b1; dn = 1'b1; end
         default: ;
      endcase
      memwrite = mw & ~reset;
      regwrite = rw & ~reset;
      irwrite = iw & ~reset;
      instr_done = dn & ~reset;
      pcen = ~reset & (pw | (br & zero));
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench driving directed opcode sequences through the control FSM
module tb_multicycle_controller;
   logic clk = 0, reset = 1, zero = 0;
   logic [5:0] op = 6'b000000;
   logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, instr_done;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;
   int errors = 0, checks = 0;

   typedef struct {string n; logic [18:0] v;} exp_t;
   exp_t q[$];

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
      .instr_done(instr_done), .state(state));

   always #5 clk = ~clk;

   // f = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca}
   function automatic logic [18:0] v(input logic [3:0] s, input logic [6:0] f, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] ps, input logic pc, input logic dn);
      return {s, f, asb, aop, ps, pc, dn};
   endfunction

   localparam logic [18:0] E_RST   = v(4'd0,  7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_FETCH = v(4'd0,  7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
   localparam logic [18:0] E_DEC   = v(4'd1,  7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_DECN  = v(4'd1,  7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
   localparam logic [18:0] E_MADR  = v(4'd2,  7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_MRD   = v(4'd3,  7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_MWB   = v(4'd4,  7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
   localparam logic [18:0] E_MWR   = v(4'd5,  7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
   localparam logic [18:0] E_MWRR  = v(4'd5,  7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_REX   = v(4'd6,  7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_RWB   = v(4'd7,  7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
   localparam logic [18:0] E_BQ0   = v(4'd8,  7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1);
   localparam logic [18:0] E_BQ1   = v(4'd8,  7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1);
   localparam logic [18:0] E_AEX   = v(4'd9,  7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
   localparam logic [18:0] E_AWB   = v(4'd10, 7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
   localparam logic [18:0] E_JEX   = v(4'd11, 7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1);
   localparam logic [18:0] E_ILL   = v(4'd13, 7'b0000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

   logic [18:0] got;
   assign got = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, aluop, pcsrc, pcen, instr_done};

   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (got !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.n, got, e.v);
         end
      end

   task automatic step(input string n, input logic [18:0] e);
      q.push_back('{n, e});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      step("reset_hold", E_RST);
      reset = 0;
      op = 6'b100011;
      step("lw_fetch", E_FETCH); step("lw_decode", E_DEC); step("lw_memadr", E_MADR);
      step("lw_memrd", E_MRD); step("lw_memwb", E_MWB);
      op = 6'b101011;
      step("sw_fetch", E_FETCH); step("sw_decode", E_DEC); step("sw_memadr", E_MADR);
      step("sw_memwr", E_MWR);
      op = 6'b000000;
      step("r_fetch", E_FETCH); step("r_decode", E_DEC); step("r_ex", E_REX); step("r_wb", E_RWB);
      op = 6'b001000;
      zero = 1;
      step("addi_fetch", E_FETCH); step("addi_decode", E_DEC); step("addi_ex", E_AEX);
      step("addi_wb", E_AWB);
      op = 6'b000100;
      zero = 0;
      step("beq0_fetch", E_FETCH); step("beq0_decode", E_DEC); step("beq0_ex", E_BQ0);
      zero = 1;
      step("beq1_fetch", E_FETCH); step("beq1_decode", E_DEC); step("beq1_ex", E_BQ1);
      op = 6'b000010;
      step("j_fetch", E_FETCH); step("j_decode", E_DEC); step("j_ex", E_JEX);
      op = 6'b111111;
      step("nop_fetch", E_FETCH); step("nop_decode", E_DECN);
      op = 6'b101011;
      zero = 0;
      step("swr_fetch", E_FETCH); step("swr_decode", E_DEC); step("swr_memadr", E_MADR);
      reset = 1;
      step("swr_memwr_reset", E_MWRR);
      reset = 0;
      step("swr_after_reset", E_FETCH);
      zero = 1;
      force dut.st = 4'd13;
      q.push_back('{"illegal_state", E_ILL});
      @(negedge clk);
      #1;
      release dut.st;
      @(posedge clk);
      #1;
      step("illegal_recover", E_FETCH);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
